// File: rtl/scrambler_lfsr_param.sv
// Parametrised XNOR-LFSR challenge scrambler with valid/ready handshakes on both sides.
// Optional all-ones lockup detection is enabled by defining SCRAMBLER_LOCKUP_DET_EN.
module scrambler_lfsr_param #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
  parameter int unsigned      ROUNDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             lockup_flag
);

  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCRAMBLE = 2'd1,
    ST_DONE     = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] chal_q, chal_d;
  logic             fb_q, fb_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_round;

  assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:     if (in_valid)   fsm_d = ST_SCRAMBLE;
      ST_SCRAMBLE: if (last_round) fsm_d = ST_DONE;
      ST_DONE:     if (out_ready)  fsm_d = ST_IDLE;
      default:                     fsm_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from the FSM state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      ST_IDLE:     in_ready  = 1'b1;
      ST_SCRAMBLE: busy      = 1'b1;
      ST_DONE:     out_valid = 1'b1;
      default:     ;
    endcase
  end

`ifdef SCRAMBLER_LOCKUP_DET_EN
  logic lockup_q, lockup_d;
`endif

  // Datapath: load on accept, one LFSR step per SCRAMBLE cycle
  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    fb_d    = fb_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
`ifdef SCRAMBLER_LOCKUP_DET_EN
    lockup_d = lockup_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          chal_d  = in_data;
          mode_d  = in_mode;
          fb_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SCRAMBLE: begin
        state_d = {state_q[WIDTH-2:0], fb_q} ^ (mode_q ? '0 : chal_q);
        fb_d    = ~^(state_q & TAPS);
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef SCRAMBLER_LOCKUP_DET_EN
        // All-ones is the XNOR-LFSR's stuck state; force a zero in to escape it
        if (&state_q) begin
          fb_d     = 1'b0;
          lockup_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      chal_q  <= '0;
      fb_q    <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      fb_q    <= fb_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SCRAMBLER_LOCKUP_DET_EN
  // Sticky lockup indicator, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= lockup_d;
    end
  end

  assign lockup_flag = lockup_q;
`else
  assign lockup_flag = 1'b0;
`endif

  assign out_data = state_q;

endmodule

// File: tb/tb_scrambler_lfsr_param.sv
// Self-checking bench for scrambler_lfsr_param: three instances (ROUNDS 8/2/1) against a
// behavioural model of the scrambling rules; honours SCRAMBLER_LOCKUP_DET_EN if defined.
module tb_scrambler_lfsr_param;

  localparam logic [7:0] TAPS = 8'hB8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      in_valid  = '0;
  logic [2:0]      in_mode   = '0;
  logic [2:0]      out_ready = '0;
  logic [2:0][7:0] in_data   = '0;
  logic [2:0]      in_ready, out_valid, busy, lockup;
  logic [2:0][7:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  bit [2:0] lk_exp = '0;
  int rnd_tbl [3] = '{8, 2, 1};

  always #5 clk = ~clk;

  scrambler_lfsr_param #(.WIDTH(8), .TAPS(8'hB8), .ROUNDS(8)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_mode(in_mode[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]), .lockup_flag(lockup[0]));

  scrambler_lfsr_param #(.WIDTH(8), .TAPS(8'hB8), .ROUNDS(2)) u_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_mode(in_mode[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]), .lockup_flag(lockup[1]));

  scrambler_lfsr_param #(.WIDTH(8), .TAPS(8'hB8), .ROUNDS(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .in_mode(in_mode[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]), .lockup_flag(lockup[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {lockup_hit, result} for one job, straight from the scrambling rules
  function automatic logic [8:0] ref_scr(input logic [7:0] chal, input logic mode, input int rounds);
    logic [7:0] s;
    logic       f, nf, hit;
    s   = chal;
    f   = 1'b0;
    hit = 1'b0;
    for (int r = 0; r < rounds; r++) begin
      nf = (($countones(s & TAPS) % 2) == 0);
`ifdef SCRAMBLER_LOCKUP_DET_EN
      if (s == 8'hFF) begin
        nf  = 1'b0;
        hit = 1'b1;
      end
`endif
      s = (((s << 1) | {7'd0, f}) & 8'hFF) ^ (mode ? 8'h00 : chal);
      f = nf;
    end
    return {hit, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One job on instance k; hold = cycles of backpressure in DONE with a competing in_valid
  task automatic run_job(input int k, input logic [7:0] d, input logic m, input int hold,
                         output logic [7:0] obs);
    logic [8:0] e;
    int n;
    e = ref_scr(d, m, rnd_tbl[k]);
    n = 0;
    chk($sformatf("k%0d accept_ready", k), 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_mode[k]  = m;
    step();
    in_valid[k] = 1'b0;
    in_data[k]  = 8'($urandom);
    in_mode[k]  = 1'($urandom);
    while (!out_valid[k] && n < 300) begin
      if (!busy[k]) chk($sformatf("k%0d busy_scramble", k), 32'(busy[k]), 32'd1);
      step();
      n++;
    end
    chk($sformatf("k%0d latency", k), 32'(n), 32'(rnd_tbl[k]));
    chk($sformatf("k%0d data d=%0h m=%0d", k, d, m), 32'(out_data[k]), 32'(e[7:0]));
    chk($sformatf("k%0d done_in_ready", k), 32'(in_ready[k]), 32'd0);
    obs = out_data[k];
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = ~d;
      step();
      chk($sformatf("k%0d hold_data", k), 32'(out_data[k]), 32'(e[7:0]));
      chk($sformatf("k%0d hold_valid", k), 32'(out_valid[k]), 32'd1);
      chk($sformatf("k%0d hold_in_ready", k), 32'(in_ready[k]), 32'd0);
    end
    in_valid[k] = 1'b0;
    if (e[8]) lk_exp[k] = 1'b1;
    chk($sformatf("k%0d lockup", k), 32'(lockup[k]), 32'(lk_exp[k]));
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    chk($sformatf("k%0d post_valid", k), 32'(out_valid[k]), 32'd0);
    chk($sformatf("k%0d post_ready", k), 32'(in_ready[k]), 32'd1);
  endtask

  task automatic chk_reset_state(input int k, input string tag);
    chk($sformatf("%s k%0d in_ready", tag, k), 32'(in_ready[k]), 32'd1);
    chk($sformatf("%s k%0d out_valid", tag, k), 32'(out_valid[k]), 32'd0);
    chk($sformatf("%s k%0d busy", tag, k), 32'(busy[k]), 32'd0);
    chk($sformatf("%s k%0d out_data", tag, k), 32'(out_data[k]), 32'd0);
    chk($sformatf("%s k%0d lockup", tag, k), 32'(lockup[k]), 32'd0);
  endtask

  initial begin
    logic [7:0] obs;
    logic [7:0] q[$];
    logic [8:0] e;
    int last_acc;
    bit acc;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk_reset_state(k, "reset");

    // Directed vectors
    run_job(2, 8'h01, 1'b0, 0, obs);
    chk("r1_m0_01", 32'(obs), 32'h03);
    run_job(1, 8'h01, 1'b0, 0, obs);
    chk("r2_m0_01", 32'(obs), 32'h06);
    run_job(1, 8'h01, 1'b1, 0, obs);
    chk("r2_m1_01", 32'(obs), 32'h05);
    run_job(1, 8'hFF, 1'b1, 0, obs);
`ifdef SCRAMBLER_LOCKUP_DET_EN
    chk("r2_m1_ff", 32'(obs), 32'hFC);
    chk("r2_m1_ff_flag", 32'(lockup[1]), 32'd1);
`else
    chk("r2_m1_ff", 32'(obs), 32'hFD);
    chk("r2_m1_ff_flag", 32'(lockup[1]), 32'd0);
`endif

    // Backpressure in DONE
    run_job(0, 8'h5A, 1'b0, 5, obs);

    // Random jobs on every instance
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 3; k++) begin
        run_job(k, (i % 5 == 4) ? 8'hFF : 8'($urandom), 1'($urandom), 0, obs);
      end
    end

    // Reset mid-SCRAMBLE drops the job
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hC3;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lk_exp = '0;
    chk_reset_state(0, "midrst");
    run_job(0, 8'h3C, 1'b0, 0, obs);

    // Back-to-back streaming on ROUNDS=8
    last_acc = -1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'($urandom);
    in_mode[0]   = 1'($urandom);
    for (int cyc = 0; cyc < 200; cyc++) begin
      acc = in_ready[0];
      if (out_valid[0]) begin
        if (q.size() == 0) chk("b2b unexpected_out", 32'(out_valid[0]), 32'd0);
        else chk($sformatf("b2b data c%0d", cyc), 32'(out_data[0]), 32'(q.pop_front()));
      end
      if (acc) begin
        e = ref_scr(in_data[0], in_mode[0], 8);
        q.push_back(e[7:0]);
        if (e[8]) lk_exp[0] = 1'b1;
        if (last_acc >= 0) chk("b2b gap", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
      end
      step();
      if (acc) begin
        in_data[0] = 8'($urandom);
        in_mode[0] = 1'($urandom);
      end
    end
    in_valid[0] = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid[0] && q.size() != 0)
        chk("b2b drain", 32'(out_data[0]), 32'(q.pop_front()));
      step();
    end
    out_ready[0] = 1'b0;
    chk("b2b leftover", 32'(q.size()), 32'd0);
    chk("b2b lockup", 32'(lockup[0]), 32'(lk_exp[0]));
    chk("b2b idle", 32'(in_ready[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
